// File: rtl/mem_stage_if.sv
// Pipeline-side signal bundle of the memory-access stage: execute input, writeback output,
// data-SRAM read word and the decode forwarding bus.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [31:0]                data_sram_rdata;
  logic [38:0]                back_to_id_stage_bus_from_mem;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, back_to_id_stage_bus_from_mem
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, back_to_id_stage_bus_from_mem
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: captures the SRAM read word, extracts/extends the load, selects the result.
// Latency 1 cycle; holds the instruction and its captured read word while ws_allowin is low.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave pipe
);

  typedef struct packed {
    logic [2:0]  load_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

  typedef struct packed {
    logic [31:0] final_result;
    logic        ms_valid;
    logic        gr_we;
    logic [4:0]  dest;
  } back_bus_t;

  typedef enum logic {
    HOLD  = 1'b0,
    ENTRY = 1'b1
  } cap_state_t;

  localparam logic MS_READY_GO = 1'b1;

  logic        ms_valid;
  es_bus_t     ms_r;
  logic [31:0] rdata_hold;
  cap_state_t  cap_state;
  cap_state_t  cap_state_nxt;
  logic [31:0] mem_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] final_result;
  logic        accept;
  ms_bus_t     ws_bus;
  back_bus_t   back_bus;

  assign pipe.ms_allowin     = !ms_valid || (MS_READY_GO && pipe.ws_allowin);
  assign pipe.ms_to_ws_valid = ms_valid && MS_READY_GO;
  assign accept              = pipe.es_to_ms_valid && pipe.ms_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (pipe.ms_allowin) begin
      ms_valid <= pipe.es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_r <= '0;
    end else if (accept) begin
      ms_r <= pipe.es_to_ms_bus;
    end
  end

  // The SRAM word is only present in the entry cycle, so it is latched then for any stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_state  <= HOLD;
      rdata_hold <= '0;
    end else begin
      cap_state <= cap_state_nxt;
      if (cap_state == ENTRY) begin
        rdata_hold <= pipe.data_sram_rdata;
      end
    end
  end

  always_comb begin
    cap_state_nxt = HOLD;
    mem_word      = rdata_hold;
    if (accept) begin
      cap_state_nxt = ENTRY;
    end
    if (cap_state == ENTRY) begin
      mem_word = pipe.data_sram_rdata;
    end
  end

  always_comb begin
    load_byte = mem_word[7:0];
    case (ms_r.alu_result[1:0])
      2'd1:    load_byte = mem_word[15:8];
      2'd2:    load_byte = mem_word[23:16];
      2'd3:    load_byte = mem_word[31:24];
      default: load_byte = mem_word[7:0];
    endcase
    load_half = ms_r.alu_result[1] ? mem_word[31:16] : mem_word[15:0];

    case (ms_r.load_type)
      3'b001:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b010:  load_value = {24'h0, load_byte};
      3'b011:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {16'h0, load_half};
      default: load_value = mem_word;
    endcase

    final_result = ms_r.res_from_mem ? load_value : ms_r.alu_result;
  end

  always_comb begin
    ws_bus.gr_we          = ms_r.gr_we;
    ws_bus.dest           = ms_r.dest;
    ws_bus.final_result   = final_result;
    ws_bus.pc             = ms_r.pc;
    back_bus.final_result = final_result;
    back_bus.ms_valid     = ms_valid;
    back_bus.gr_we        = ms_r.gr_we;
    back_bus.dest         = ms_r.dest;
  end

  assign pipe.ms_to_ws_bus                  = ws_bus;
  assign pipe.back_to_id_stage_bus_from_mem = back_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: literal checks on the test-plan vectors plus a per-cycle
// comparison against an instruction-level model of the stage.
module tb_mem_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_stage_if #() ifc ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .pipe  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [73:0] mk(input logic [2:0] lt, input logic rfm, input logic we,
                                     input logic [4:0] d, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {lt, rfm, we, d, alu, pc};
  endfunction

  // Load result from the instruction fields and the memory word, by shifting and extending.
  function automatic logic [31:0] model_result(input logic [73:0] b, input logic [31:0] w);
    logic [31:0] alu;
    logic [7:0]  by;
    logic [15:0] hf;
    int          sh;
    alu = b[63:32];
    if (!b[70]) return alu;
    sh = 8 * int'(alu[1:0]);
    by = 8'(w >> sh);
    hf = 16'(w >> (alu[1] ? 16 : 0));
    case (b[73:71])
      3'd1:    return {{24{by[7]}}, by};
      3'd2:    return {24'h0, by};
      3'd3:    return {{16{hf[15]}}, hf};
      3'd4:    return {16'h0, hf};
      default: return w;
    endcase
  endfunction

  // Instruction-level model: which instruction occupies the stage and its memory word.
  logic        m_valid;
  logic        m_first;
  logic [73:0] m_bus;
  logic [31:0] m_word;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_first = 1'b0;
      m_bus   = '0;
    end else begin
      m_first = 1'b0;
      if (!m_valid || ifc.ws_allowin) begin
        m_valid = ifc.es_to_ms_valid;
        if (ifc.es_to_ms_valid) begin
          m_bus   = ifc.es_to_ms_bus;
          m_first = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] fin;
    if (!reset) begin
      if (m_valid && m_first) m_word = ifc.data_sram_rdata;
      check("model_allowin", 64'(ifc.ms_allowin), 64'(!m_valid || ifc.ws_allowin));
      check("model_valid", 64'(ifc.ms_to_ws_valid), 64'(m_valid));
      if (m_valid) begin
        fin = model_result(m_bus, m_word);
        check("model_ws_hi", 64'(ifc.ms_to_ws_bus[69:32]), 64'({m_bus[69:64], fin}));
        check("model_ws_pc", 64'(ifc.ms_to_ws_bus[31:0]), 64'(m_bus[31:0]));
        check("model_back", 64'(ifc.back_to_id_stage_bus_from_mem),
              64'({fin, 1'b1, m_bus[69:64]}));
      end else begin
        check("model_back_vld", 64'(ifc.back_to_id_stage_bus_from_mem[6]), 64'(0));
      end
    end
  end

  task automatic drive(input logic v, input logic [73:0] b, input logic [31:0] rd,
                       input logic wa);
    ifc.es_to_ms_valid  = v;
    ifc.es_to_ms_bus    = b;
    ifc.data_sram_rdata = rd;
    ifc.ws_allowin      = wa;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lit_result(input string name, input logic [31:0] exp);
    check({name, "_valid"}, 64'(ifc.ms_to_ws_valid), 64'(1));
    check({name, "_result"}, 64'(ifc.ms_to_ws_bus[63:32]), 64'(exp));
  endtask

  task automatic lit_reset_state(input string name);
    check({name, "_ws_valid"}, 64'(ifc.ms_to_ws_valid), 64'(0));
    check({name, "_allowin"}, 64'(ifc.ms_allowin), 64'(1));
    check({name, "_ws_bus_lo"}, 64'(ifc.ms_to_ws_bus[63:0]), 64'(0));
    check({name, "_ws_bus_hi"}, 64'(ifc.ms_to_ws_bus[69:64]), 64'(0));
    check({name, "_back"}, 64'(ifc.back_to_id_stage_bus_from_mem), 64'(0));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ifc.es_to_ms_valid  = 1'b0;
    ifc.es_to_ms_bus    = '0;
    ifc.data_sram_rdata = '0;
    ifc.ws_allowin      = 1'b0;
    #1;
    lit_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // LW, result one cycle after accept
    drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd3, 32'h1000, 32'h100), 32'h0, 1'b1);
    tick;
    drive(1'b0, '0, 32'hDEADBEEF, 1'b1);
    lit_result("lw", 32'hDEADBEEF);
    tick;

    // LB, LBU, LH, LHU back-to-back on the same memory word
    drive(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd4, 32'h1003, 32'h104), 32'h0, 1'b1);
    tick;
    drive(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd4, 32'h1003, 32'h108), 32'h80112233, 1'b1);
    lit_result("lb", 32'hFFFFFF80);
    tick;
    drive(1'b1, mk(3'd3, 1'b1, 1'b1, 5'd4, 32'h1002, 32'h10C), 32'h80112233, 1'b1);
    lit_result("lbu", 32'h00000080);
    tick;
    drive(1'b1, mk(3'd4, 1'b1, 1'b1, 5'd4, 32'h1002, 32'h110), 32'h80112233, 1'b1);
    lit_result("lh", 32'hFFFF8011);
    tick;
    drive(1'b0, '0, 32'h80112233, 1'b1);
    lit_result("lhu", 32'h00008011);
    tick;

    // Back-to-back LW
    drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd6, 32'h2000, 32'h200), 32'h0, 1'b1);
    tick;
    drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd7, 32'h2004, 32'h204), 32'h1, 1'b1);
    lit_result("b2b_first", 32'h1);
    tick;
    drive(1'b0, '0, 32'h2, 1'b1);
    lit_result("b2b_second", 32'h2);
    check("b2b_pc", 64'(ifc.ms_to_ws_bus[31:0]), 64'h204);
    tick;

    // Stall: word captured on entry must survive changing SRAM data
    drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd8, 32'h3000, 32'h300), 32'h0, 1'b0);
    tick;
    drive(1'b0, '0, 32'h12345678, 1'b0);
    lit_result("stall1", 32'h12345678);
    check("stall1_allowin", 64'(ifc.ms_allowin), 64'(0));
    tick;
    drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd9, 32'hBAD0, 32'hBAD), 32'hAAAAAAAA, 1'b0);
    lit_result("stall2", 32'h12345678);
    check("stall2_allowin", 64'(ifc.ms_allowin), 64'(0));
    tick;
    drive(1'b0, '0, 32'hAAAAAAAA, 1'b0);
    lit_result("stall3", 32'h12345678);
    check("stall3_pc", 64'(ifc.ms_to_ws_bus[31:0]), 64'h300);
    tick;
    drive(1'b0, '0, 32'hAAAAAAAA, 1'b1);
    lit_result("stall_release", 32'h12345678);
    check("stall_release_allowin", 64'(ifc.ms_allowin), 64'(1));
    tick;
    drive(1'b0, '0, 32'hAAAAAAAA, 1'b1);
    check("stall_left", 64'(ifc.ms_to_ws_valid), 64'(0));

    // Non-load: ALU result forwarded, back bus fields
    drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd5, 32'h00000042, 32'h400), 32'hFFFFFFFF, 1'b1);
    tick;
    drive(1'b0, '0, 32'hFFFFFFFF, 1'b1);
    lit_result("alu", 32'h42);
    check("alu_back", 64'(ifc.back_to_id_stage_bus_from_mem), 64'({32'h42, 1'b1, 1'b1, 5'd5}));
    tick;

    // Asynchronous reset while a stalled instruction is held
    drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd10, 32'h5000, 32'h500), 32'h0, 1'b0);
    tick;
    drive(1'b0, '0, 32'h55, 1'b0);
    tick;
    drive(1'b0, '0, 32'h66, 1'b0);
    lit_result("prereset", 32'h55);
    reset = 1'b1;
    #1;
    lit_reset_state("midreset");
    tick;
    reset = 1'b0;

    drive(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd11, 32'h6001, 32'h600), 32'h0, 1'b1);
    tick;
    drive(1'b0, '0, 32'h0000F700, 1'b1);
    lit_result("post_reset_lb", 32'hFFFFFFF7);
    tick;
    drive(1'b0, '0, 32'h0, 1'b1);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
